// File: rtl/rv64g_l1_traffic_gen_if.sv
// L1 dcache CPU-side request bus: req/gnt handshake plus rvalid read return.
// Latency: none; this is wiring only.
// Backpressure: the master holds req and its payload until gnt is seen high.
// Ports: req/we/be/addr/wdata from master; gnt/rvalid/rdata from slave.
interface rv64g_l1_traffic_gen_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  localparam int BE_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/rv64g_l1_traffic_gen.sv
// Self-checking L1 dcache traffic generator: LFSR-driven ops, per-byte shadow scoreboard.
// Latency: one request per op, ISSUE -> WAIT_GNT (-> WAIT_RV) -> GAP, so >= 3 cycles per op.
// Backpressure: request fields stay frozen until gnt; a wait of MAX_WAIT cycles aborts the run.
// Ports: clk_i/rst_i; start_i/mode_i/seed_i run control; bus (master) to the cache;
//        busy_o/done_o/pass_o/timeout_o/err_cnt_o/ops_done_o run status.
module rv64g_l1_traffic_gen #(
  parameter int                DATA_W       = 64,
  parameter int                ADDR_W       = 64,
  parameter int                NUM_OPS      = 16,
  parameter int                SHADOW_DEPTH = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h1000,
  parameter int                MAX_WAIT     = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [15:0] seed_i,
  rv64g_l1_traffic_gen_if.master bus,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] ops_done_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [15:0]       NUM_OPS_L = 16'(NUM_OPS);
  localparam logic [15:0]       HALF_OPS  = 16'(NUM_OPS / 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_GNT = 3'd2;
  localparam logic [2:0] S_WAIT_RV  = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [15:0]       lfsr;
  logic [15:0]       k;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       err_cnt;
  logic [15:0]       ops_done;
  logic              timeout_q;
  logic              done_q;

  logic              req_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [IDX_W-1:0]  idx_q;

  logic [DATA_W-1:0] shadow_dat [SHADOW_DEPTH];
  logic [BE_W-1:0]   shadow_vld [SHADOW_DEPTH];

  // Galois form, taps x^16+x^14+x^13+x^11 -> feedback mask 0xB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Op fields for op index k. They use the LFSR value current in ISSUE;
  // the LFSR steps on the same edge, so op 0 is derived from the seed itself.
  logic              op_we;
  logic [15:0]       op_idx16;
  logic [IDX_W-1:0]  op_idx;
  logic [BE_W-1:0]   op_be;
  logic [BE_W-1:0]   rnd_be;
  logic [15:0]       op_pat;
  logic [DATA_W-1:0] op_wdata;
  logic [ADDR_W-1:0] op_addr;

  always_comb begin
    op_we    = 1'b0;
    op_idx16 = '0;
    op_be    = '1;
    rnd_be   = '0;
    op_pat   = k ^ 16'hA5A5 ^ lfsr;
    op_wdata = '0;
    for (int i = 0; i < DATA_W / 16; i++) begin
      op_wdata[i*16 +: 16] = op_pat;
    end
    for (int i = 0; i < BE_W; i++) begin
      rnd_be[i] = lfsr[8 + (i % 8)];
    end
    case (mode_q)
      2'd1: begin
        op_we    = ~k[0];
        op_idx16 = k >> 1;
      end
      2'd2: begin
        op_we    = lfsr[0];
        op_idx16 = {8'h00, lfsr[8:1]};
        op_be    = (rnd_be == '0) ? '1 : rnd_be;
      end
      default: begin
        if (k < HALF_OPS) begin
          op_we    = 1'b1;
          op_idx16 = k;
        end else begin
          op_we    = 1'b0;
          op_idx16 = k - HALF_OPS;
        end
      end
    endcase
  end

  assign op_idx  = op_idx16[IDX_W-1:0];
  assign op_addr = BASE_ADDR + ADDR_W'(op_idx) * ADDR_W'(BE_W);

  // Read check covers only bytes this run has written; stale bytes are don't-care.
  logic rd_mismatch;
  always_comb begin
    rd_mismatch = 1'b0;
    for (int b = 0; b < BE_W; b++) begin
      if (shadow_vld[idx_q][b] &&
          (bus.rdata[b*8 +: 8] != shadow_dat[idx_q][b*8 +: 8])) begin
        rd_mismatch = 1'b1;
      end
    end
  end

  logic wr_commit;
  logic rd_return;
  logic err_inc;

  assign wr_commit = (state == S_WAIT_GNT) && bus.gnt && we_q;
  assign rd_return = (state == S_WAIT_RV) && bus.rvalid;
  // A mismatch and a spurious rvalid are mutually exclusive, so one step suffices.
  assign err_inc   = (bus.rvalid && (state != S_WAIT_RV)) || (rd_return && rd_mismatch);

  always_ff @(posedge clk_i) begin
    if (wr_commit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_q[b]) shadow_dat[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      lfsr      <= '0;
      k         <= '0;
      wait_cnt  <= '0;
      err_cnt   <= '0;
      ops_done  <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      for (int i = 0; i < SHADOW_DEPTH; i++) shadow_vld[i] <= '0;
    end else begin
      if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            mode_q    <= mode_i;
            lfsr      <= (seed_i == 16'h0000) ? 16'hACE1 : seed_i;
            k         <= '0;
            err_cnt   <= '0;
            ops_done  <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < SHADOW_DEPTH; i++) shadow_vld[i] <= '0;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          we_q     <= op_we;
          be_q     <= op_be;
          addr_q   <= op_addr;
          wdata_q  <= op_wdata;
          idx_q    <= op_idx;
          req_q    <= 1'b1;
          lfsr     <= lfsr_step(lfsr);
          wait_cnt <= '0;
          state    <= S_WAIT_GNT;
        end

        S_WAIT_GNT: begin
          if (bus.gnt) begin
            req_q <= 1'b0;
            if (we_q) begin
              shadow_vld[idx_q] <= shadow_vld[idx_q] | be_q;
              ops_done          <= ops_done + 16'd1;
              state             <= S_GAP;
            end else begin
              wait_cnt <= '0;
              state    <= S_WAIT_RV;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // wait_cnt counts cycles already spent, so req is held MAX_WAIT cycles.
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_WAIT_RV: begin
          if (bus.rvalid) begin
            ops_done <= ops_done + 16'd1;
            state    <= S_GAP;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_GAP: begin
          k <= k + 16'd1;
          if (k + 16'd1 == NUM_OPS_L) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_ISSUE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.be    = be_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

  assign busy_o     = (state == S_ISSUE) || (state == S_WAIT_GNT) ||
                      (state == S_WAIT_RV) || (state == S_GAP);
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;
  assign err_cnt_o  = err_cnt;
  assign ops_done_o = ops_done;
  assign pass_o     = done_q && (err_cnt == 16'h0000) && !timeout_q;

endmodule

// File: tb/tb_rv64g_l1_traffic_gen.sv
// Directed bench for rv64g_l1_traffic_gen: a configurable cache responder plus scenario tasks.
module tb_rv64g_l1_traffic_gen;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 64;
  localparam int NUM_OPS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] seed = 16'h0000;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt, ops_done;

  rv64g_l1_traffic_gen_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rv64g_l1_traffic_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_OPS(NUM_OPS),
    .SHADOW_DEPTH(16), .BASE_ADDR(64'h1000), .MAX_WAIT(255)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .seed_i(seed),
    .bus(bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .err_cnt_o(err_cnt), .ops_done_o(ops_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Responder knobs
  bit gnt_en   = 1'b1;
  int gnt_dly  = 1;
  int rv_dly   = 2;
  int flip_rd  = 0;
  bit spur_arm = 1'b0;

  // Responder state
  logic [63:0] mem [16];
  int gcnt = 0, rv_cnt = 0, rd_num = 0, rv_idx = 0;
  bit rv_pend = 1'b0, spur_now = 1'b0, rv_flip = 1'b0;

  logic [63:0] log_addr[$];
  logic        log_we[$];
  logic [7:0]  log_be[$];
  logic [63:0] log_wdata[$];

  task automatic respond();
    int idx;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    if (rst) begin
      gcnt = 0; rv_pend = 1'b0; spur_now = 1'b0;
      return;
    end
    if (rv_pend) begin
      if (rv_cnt <= 1) begin
        bus.rvalid = 1'b1;
        bus.rdata  = mem[rv_idx] ^ (rv_flip ? 64'h1 : 64'h0);
        rv_pend    = 1'b0;
      end else begin
        rv_cnt--;
      end
    end else if (spur_now) begin
      bus.rvalid = 1'b1;
      bus.rdata  = 64'h0;
      spur_now   = 1'b0;
    end
    if (bus.req && gnt_en) begin
      if (gcnt >= gnt_dly) begin
        bus.gnt = 1'b1;
        gcnt    = 0;
        idx     = int'(((bus.addr - 64'h1000) >> 3) & 64'hF);
        log_addr.push_back(bus.addr);
        log_we.push_back(bus.we);
        log_be.push_back(bus.be);
        log_wdata.push_back(bus.wdata);
        if (bus.we) begin
          for (int b = 0; b < 8; b++)
            if (bus.be[b]) mem[idx][b*8 +: 8] = bus.wdata[b*8 +: 8];
          if (spur_arm) begin spur_arm = 1'b0; spur_now = 1'b1; end
        end else begin
          rd_num++;
          rv_pend = 1'b1;
          rv_cnt  = rv_dly;
          rv_idx  = idx;
          rv_flip = (rd_num == flip_rd);
        end
      end else begin
        gcnt++;
      end
    end else begin
      gcnt = 0;
    end
  endtask

  initial begin
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    forever begin
      @(negedge clk);
      respond();
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [15:0] s);
    log_addr.delete(); log_we.delete(); log_be.delete(); log_wdata.delete();
    rd_num = 0;
    @(negedge clk);
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_done_wait: done_o=%0b required 1 within 4000 cycles", name, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({busy, done, pass, timeout, bus.req} !== 5'b0) begin fails++;
      $display("FAIL reset_flags: busy/done/pass/timeout/req=%b required 00000", {busy, done, pass, timeout, bus.req}); end
    tests++; if (err_cnt !== 16'h0 || ops_done !== 16'h0) begin fails++;
      $display("FAIL reset_counters: err=%0d ops=%0d required 0 0", err_cnt, ops_done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0 || bus.req !== 1'b0) begin fails++;
      $display("FAIL idle_no_start: busy=%0b req=%0b required 0 0", busy, bus.req); end
  endtask

  task automatic test_fill_check();
    start_run(2'd0, 16'h1234);
    wait_done("fill");
    tests++; if (log_addr.size() != 8) begin fails++;
      $display("FAIL fill_op_count: %0d granted required 8", log_addr.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (log_we[i] !== (i < 4) || log_addr[i] !== 64'h1000 + 64'((i % 4) * 8) || log_be[i] !== 8'hFF) begin
          fails++;
          $display("FAIL fill_op%0d: we=%0b addr=%h be=%h required we=%0b addr=%h be=ff",
                   i, log_we[i], log_addr[i], log_be[i], (i < 4), 64'h1000 + 64'((i % 4) * 8));
        end
      end
      tests++; if (log_wdata[0] !== 64'hB791B791B791B791) begin fails++;
        $display("FAIL fill_wdata0: %h required b791b791b791b791", log_wdata[0]); end
      tests++; if (log_wdata[1] !== 64'hACBEACBEACBEACBE) begin fails++;
        $display("FAIL fill_wdata1: %h required acbeacbeacbeacbe", log_wdata[1]); end
    end
    tests++; if ({done, pass, timeout, busy} !== 4'b1100) begin fails++;
      $display("FAIL fill_status: done/pass/timeout/busy=%b required 1100", {done, pass, timeout, busy}); end
    tests++; if (ops_done !== 16'd8 || err_cnt !== 16'd0) begin fails++;
      $display("FAIL fill_counts: ops=%0d err=%0d required 8 0", ops_done, err_cnt); end
  endtask

  task automatic test_pairs_mismatch();
    flip_rd = 2;
    start_run(2'd1, 16'h00FF);
    wait_done("pairs");
    flip_rd = 0;
    tests++; if (log_addr.size() != 8) begin fails++;
      $display("FAIL pairs_op_count: %0d granted required 8", log_addr.size()); end
    else begin
      tests++; if (log_we[2] !== 1'b1 || log_we[3] !== 1'b0 || log_addr[3] !== 64'h1008) begin fails++;
        $display("FAIL pairs_op3: we2=%0b we3=%0b addr3=%h required 1 0 1008", log_we[2], log_we[3], log_addr[3]); end
    end
    tests++; if (err_cnt !== 16'd1 || ops_done !== 16'd8) begin fails++;
      $display("FAIL pairs_counts: err=%0d ops=%0d required 1 8", err_cnt, ops_done); end
    tests++; if (pass !== 1'b0 || done !== 1'b1) begin fails++;
      $display("FAIL pairs_status: pass=%0b done=%0b required 0 1", pass, done); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int addr_bad = 0;
    gnt_en = 1'b0;
    start_run(2'd0, 16'h0001);
    for (int c = 0; c < 2000; c++) begin
      if (done) break;
      if (bus.req) begin
        req_cycles++;
        if (bus.addr !== 64'h1000 || bus.we !== 1'b1 || bus.be !== 8'hFF) addr_bad++;
      end
      @(negedge clk);
    end
    gnt_en = 1'b1;
    tests++; if (req_cycles != 255) begin fails++;
      $display("FAIL timeout_req_len: req high %0d cycles required 255", req_cycles); end
    tests++; if (addr_bad != 0) begin fails++;
      $display("FAIL timeout_req_stable: %0d unstable cycles required 0", addr_bad); end
    tests++; if ({timeout, done, pass, bus.req} !== 4'b1100) begin fails++;
      $display("FAIL timeout_status: timeout/done/pass/req=%b required 1100", {timeout, done, pass, bus.req}); end
    tests++; if (ops_done !== 16'd0) begin fails++;
      $display("FAIL timeout_ops: %0d required 0", ops_done); end
  endtask

  task automatic test_random(input logic [15:0] s);
    start_run(2'd2, s);
    wait_done("random");
    tests++; if (log_addr.size() != 8) begin fails++;
      $display("FAIL random_op_count seed=%h: %0d granted required 8", s, log_addr.size()); end
    else begin
      tests++; if (log_we[0] !== 1'b1 || log_addr[0] !== 64'h1000 || log_be[0] !== 8'hAC ||
                   log_wdata[0] !== 64'h0944094409440944) begin fails++;
        $display("FAIL random_op0 seed=%h: we=%0b addr=%h be=%h wdata=%h required 1 1000 ac 0944094409440944",
                 s, log_we[0], log_addr[0], log_be[0], log_wdata[0]); end
      tests++; if (log_we[1] !== 1'b0 || log_addr[1] !== 64'h1040) begin fails++;
        $display("FAIL random_op1 seed=%h: we=%0b addr=%h required 0 1040", s, log_we[1], log_addr[1]); end
    end
    tests++; if (pass !== 1'b1 || ops_done !== 16'd8 || err_cnt !== 16'd0) begin fails++;
      $display("FAIL random_status seed=%h: pass=%0b ops=%0d err=%0d required 1 8 0", s, pass, ops_done, err_cnt); end
  endtask

  task automatic test_spurious();
    spur_arm = 1'b1;
    start_run(2'd0, 16'h5A5A);
    wait_done("spurious");
    tests++; if (err_cnt !== 16'd1 || ops_done !== 16'd8) begin fails++;
      $display("FAIL spurious_counts: err=%0d ops=%0d required 1 8", err_cnt, ops_done); end
    tests++; if (pass !== 1'b0 || timeout !== 1'b0) begin fails++;
      $display("FAIL spurious_status: pass=%0b timeout=%0b required 0 0", pass, timeout); end
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    rv_dly = 20;
    start_run(2'd0, 16'h0042);
    for (int c = 0; c < 400; c++) begin
      if (log_addr.size() >= 5) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!seen) begin fails++;
      $display("FAIL midrun_first_read: %0d grants required 5 within 400 cycles", log_addr.size()); end
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b1 || bus.req !== 1'b0 || ops_done !== 16'd4) begin fails++;
      $display("FAIL midrun_pre_reset: busy=%0b req=%0b ops=%0d required 1 0 4", busy, bus.req, ops_done); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({busy, done, pass, timeout, bus.req} !== 5'b0 || err_cnt !== 16'd0 || ops_done !== 16'd0) begin fails++;
      $display("FAIL midrun_reset_outputs: flags=%b err=%0d ops=%0d required 00000 0 0",
               {busy, done, pass, timeout, bus.req}, err_cnt, ops_done); end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    rv_dly = 2;
    repeat (3) @(negedge clk);
    tests++; if (bus.req !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL midrun_abandoned: req=%0b busy=%0b required 0 0", bus.req, busy); end
    start_run(2'd0, 16'h0042);
    wait_done("fresh");
    tests++; if (err_cnt !== 16'd0 || ops_done !== 16'd8 || pass !== 1'b1) begin fails++;
      $display("FAIL fresh_run: err=%0d ops=%0d pass=%0b required 0 8 1", err_cnt, ops_done, pass); end
  endtask

  initial begin
    test_reset();
    test_fill_check();
    test_pairs_mismatch();
    test_timeout();
    test_random(16'h0000);
    test_random(16'hACE1);
    test_spurious();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 required finish earlier");
    $fatal(1, "watchdog expired");
  end
endmodule
